// File: rtl/serial_sub_if.sv
// Host-side handshake and operand bus for the bit-serial subtractor controller.
// The host drives the master modport; serial_sub_ctrl is the slave.
interface serial_sub_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             en;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   modport master (
      output start, a, b, bin, en,
      input  busy, done, diff, bout
   );

   modport slave (
      input  start, a, b, bin, en,
      output busy, done, diff, bout
   );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per enabled cycle,
// LSB first, wrapped in a start/busy/done handshake.
module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   serial_sub_if.slave  bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] sa_r;
   logic [WIDTH-1:0] sb_r;
   logic [WIDTH-1:0] sr_r;
   logic             br_r;
   logic [CW-1:0]    cnt_r;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] diff_r;
   logic             bout_r;

   logic [1:0]       step_s;
   logic [WIDTH-1:0] sr_next_s;

   // One-bit full subtract; returns {borrow_out, difference}.
   function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
      full_sub = {(~x & y) | (~(x ^ y) & bi), x ^ y ^ bi};
   endfunction

   // Current step result and the result shifter with the new bit entering at the MSB.
   always_comb begin
      step_s               = full_sub(sa_r[0], sb_r[0], br_r);
      sr_next_s            = sr_r >> 1'b1;
      sr_next_s[WIDTH-1]   = step_s[0];
   end

   // Control FSM and datapath; diff/bout only change on the final RUN step.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         sa_r    <= '0;
         sb_r    <= '0;
         sr_r    <= '0;
         br_r    <= 1'b0;
         cnt_r   <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         diff_r  <= '0;
         bout_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  sa_r    <= bus.a;
                  sb_r    <= bus.b;
                  br_r    <= bus.bin;
                  sr_r    <= '0;
                  cnt_r   <= '0;
                  busy_r  <= 1'b1;
                  state_r <= ST_RUN;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (bus.en) begin
                  sa_r  <= sa_r >> 1'b1;
                  sb_r  <= sb_r >> 1'b1;
                  sr_r  <= sr_next_s;
                  br_r  <= step_s[1];
                  cnt_r <= cnt_r + CW'(1);
                  if (cnt_r == LAST_CNT) begin
                     diff_r  <= sr_next_s;
                     bout_r  <= step_s[1];
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     state_r <= ST_DONE;
                  end else begin
                     state_r <= ST_RUN;
                  end
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.diff = diff_r;
   assign bus.bout = bout_r;
endmodule
